conv_loop_ctrl: RTL
===================

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning input-depth counter width.
REQ-002 SHALL have parameter OD_W, default 8, meaning output-depth counter width.
REQ-003 SHALL have parameter DIM_W, default 9, meaning feature-map width/height field width.
REQ-004 SHALL have parameter BLK_W, default 8, meaning block-dimension width; block count is 2*BLK_W bits.
REQ-005 SHALL have parameter TILE_OUT, default 6, meaning output pixels per tile edge.
REQ-006 SHALL have parameter OD_PAR, default 2, meaning output channels processed per pass (>=1).
REQ-007 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_wen_i  in  1  latch cfg_* fields.
- cfg_id_i  in  ID_W  input-depth count.
- cfg_od_i  in  OD_W  output-depth count.
- cfg_width_i, cfg_height_i  in  DIM_W each  map dimensions.
- cfg_size_type_i  in  1  kernel size type.
- start_i  in  1  begin layer.
- loop_finished_i  in  1  data controller tile-loop done pulse.
- weight_od_base_o  out  OD_W  first od of current group.
- weight_id_o, data_id_o  out  ID_W  current id.
- od_valid_mask_o  out  OD_PAR  lane k valid.
- data_prepare_o  out  1  data controller run request.
- size_type_o  out  1  latched size type.
- block_width_o, block_height_o  out  BLK_W  tiles per row/column.
- block_cnt_o  out  2*BLK_W  block_width_o*block_height_o.
- busy_o, conv_completed_o, cfg_err_o  out  1 each.

Function
REQ-008 SHALL implement states IDLE, PREPARE, ADVANCE, DONE.
REQ-009 IDLE->PREPARE on start_i when cfg_err_o=0 and cfg_wen_i=0; start_i with cfg_wen_i same cycle SHALL be ignored.
REQ-010 PREPARE->ADVANCE on loop_finished_i; loop_finished_i in any other state SHALL be ignored.
REQ-011 ADVANCE SHALL last exactly one cycle: ->DONE if last group, else ->PREPARE.
REQ-012 DONE SHALL hold; start_i in DONE SHALL clear counters and go to PREPARE next cycle.
REQ-013 Loop order: od innermost in steps of OD_PAR, then id; in ADVANCE, if od_base+OD_PAR>=total_od then od_base<=0, id<=id+1, else od_base<=od_base+OD_PAR.
REQ-014 Last group: od_base+OD_PAR>=total_od and id==total_id-1, compared at OD_W+1 / ID_W+1 bits (no wrap).
REQ-015 od_valid_mask_o[k]=1 iff od_base+k<total_od.
REQ-016 data_prepare_o=1 only in PREPARE (Moore); busy_o=1 in PREPARE/ADVANCE; conv_completed_o=1 only in DONE.
REQ-017 block_width_o=max(1,ceil(width/TILE_OUT)), saturating at 2^BLK_W-1; same for height; registered one cycle after cfg_wen_i.
REQ-018 block_cnt_o SHALL be the full-width product, no truncation.
REQ-019 cfg_wen_i SHALL be honoured only in IDLE/DONE; ignored while busy_o=1; a write in DONE returns to IDLE.
REQ-020 cfg_err_o=1 when latched total_id==0 or total_od==0.

Reset
REQ-021 Reset SHALL force state IDLE; all config registers, counters and outputs 0, except block_width_o=block_height_o=1, block_cnt_o=1 and od_valid_mask_o=0.
REQ-022 Reset mid-operation SHALL abort immediately; no completion indication.
REQ-023 cfg_err_o SHALL be 1 out of reset (latched counts are 0).

Configuration
REQ-024 With CONV_PERF_CNT_EN defined, SHALL add output perf_cycles_o[31:0] counting cycles with busy_o=1 since last start, saturating at all-ones, frozen in DONE, cleared on start and reset.
REQ-025 Without CONV_PERF_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package conv_ctrl_pkg SHALL hold the state enum and default TILE_OUT/OD_PAR/width constants.
REQ-027 Sub-module tile_ceil_div (dimension -> saturated ceil block count) SHALL be instantiated twice.

Verification
REQ-028 id=2, od=4, width=13, height=7 -> blocks 3x2, cnt 6; groups (od,id)=(0,0),(2,0),(0,1),(2,1); conv_completed_o one cycle after 4th ADVANCE.
REQ-029 od=5 -> third group od_base=4, od_valid_mask_o=2'b01; earlier groups 2'b11.
REQ-030 cfg id=0 -> cfg_err_o=1, start_i ignored, remains IDLE.
REQ-031 width=0 -> block_width_o=1; width=511 -> 86; loop_finished_i in IDLE -> no state change.
REQ-032 reset asserted in PREPARE -> all outputs at reset values next evaluation; restart from DONE via start_i -> id=0, od_base=0.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and default geometry for the convolution loop controller.
package conv_ctrl_pkg;

    localparam int DEF_ID_W     = 4;
    localparam int DEF_OD_W     = 8;
    localparam int DEF_DIM_W    = 9;
    localparam int DEF_BLK_W    = 8;
    localparam int DEF_TILE_OUT = 6;
    localparam int DEF_OD_PAR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREPARE = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_loop_ctrl_tile_ceil_div.sv
// Feature-map dimension -> number of output tiles, at least 1 and saturated to the block field.
module tile_ceil_div
    import conv_ctrl_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W,
    parameter int BLK_W = DEF_BLK_W,
    parameter int TILE  = DEF_TILE_OUT
) (
    input  logic [DIM_W-1:0] dim,
    output logic [BLK_W-1:0] blocks
);

    localparam int CW = ((DIM_W > BLK_W) ? DIM_W : BLK_W) + 1;
    localparam logic [CW-1:0] BLK_MAX = CW'((2 ** BLK_W) - 1);

    logic [CW-1:0] quot;

    always_comb begin
        quot = (CW'(dim) + CW'(TILE - 1)) / CW'(TILE);
        if (quot == '0)
            blocks = BLK_W'(1);
        else if (quot > BLK_MAX)
            blocks = BLK_MAX[BLK_W-1:0];
        else
            blocks = quot[BLK_W-1:0];
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Layer-level loop controller: walks (od group, id) pairs, handing each to the data controller.
// Optional cycle counter perf_cycles_o is built when CONV_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for configuration / start
// PREPARE  | data controller running the tile loop for current group
// ADVANCE  | one cycle: step od_base / id to the next group
// DONE     | layer finished, holding until start or a new config write
module conv_loop_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int ID_W     = DEF_ID_W,
    parameter int OD_W     = DEF_OD_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int BLK_W    = DEF_BLK_W,
    parameter int TILE_OUT = DEF_TILE_OUT,
    parameter int OD_PAR   = DEF_OD_PAR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wen_i,
    input  logic [ID_W-1:0]      cfg_id_i,
    input  logic [OD_W-1:0]      cfg_od_i,
    input  logic [DIM_W-1:0]     cfg_width_i,
    input  logic [DIM_W-1:0]     cfg_height_i,
    input  logic                 cfg_size_type_i,
    input  logic                 start_i,
    input  logic                 loop_finished_i,
    output logic [OD_W-1:0]      weight_od_base_o,
    output logic [ID_W-1:0]      weight_id_o,
    output logic [ID_W-1:0]      data_id_o,
    output logic [OD_PAR-1:0]    od_valid_mask_o,
    output logic                 data_prepare_o,
    output logic                 size_type_o,
    output logic [BLK_W-1:0]     block_width_o,
    output logic [BLK_W-1:0]     block_height_o,
    output logic [2*BLK_W-1:0]   block_cnt_o,
    output logic                 busy_o,
    output logic                 conv_completed_o,
    output logic                 cfg_err_o
`ifdef CONV_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles_o
`endif
);

    conv_state_t     state;
    logic [OD_W-1:0] od_base;
    logic [ID_W-1:0] id_cnt;
    logic [ID_W-1:0] total_id;
    logic [OD_W-1:0] total_od;
    logic [BLK_W-1:0] blk_w_calc;
    logic [BLK_W-1:0] blk_h_calc;
    logic            od_wrap;
    logic            last_grp;
    logic            cfg_take;
    logic            start_ok;

    tile_ceil_div #(.DIM_W(DIM_W), .BLK_W(BLK_W), .TILE(TILE_OUT)) u_div_w (
        .dim    (cfg_width_i),
        .blocks (blk_w_calc)
    );

    tile_ceil_div #(.DIM_W(DIM_W), .BLK_W(BLK_W), .TILE(TILE_OUT)) u_div_h (
        .dim    (cfg_height_i),
        .blocks (blk_h_calc)
    );

    // One extra bit on both sides so od_base+OD_PAR and id+1 cannot wrap.
    assign od_wrap  = ({1'b0, od_base} + (OD_W+1)'(OD_PAR)) >= {1'b0, total_od};
    assign last_grp = od_wrap && (({1'b0, id_cnt} + (ID_W+1)'(1)) == {1'b0, total_id});

    assign cfg_err_o = (total_id == '0) || (total_od == '0);
    assign cfg_take  = cfg_wen_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign start_ok  = start_i && !cfg_wen_i && !cfg_err_o
                       && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_id       <= '0;
            total_od       <= '0;
            size_type_o    <= 1'b0;
            block_width_o  <= BLK_W'(1);
            block_height_o <= BLK_W'(1);
            block_cnt_o    <= (2*BLK_W)'(1);
        end else if (cfg_take) begin
            total_id       <= cfg_id_i;
            total_od       <= cfg_od_i;
            size_type_o    <= cfg_size_type_i;
            block_width_o  <= blk_w_calc;
            block_height_o <= blk_h_calc;
            block_cnt_o    <= (2*BLK_W)'(blk_w_calc) * (2*BLK_W)'(blk_h_calc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            od_base          <= '0;
            id_cnt           <= '0;
            data_prepare_o   <= 1'b0;
            busy_o           <= 1'b0;
            conv_completed_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE && cfg_take) begin
                        state            <= ST_IDLE;
                        conv_completed_o <= 1'b0;
                    end else if (start_ok) begin
                        state            <= ST_PREPARE;
                        od_base          <= '0;
                        id_cnt           <= '0;
                        data_prepare_o   <= 1'b1;
                        busy_o           <= 1'b1;
                        conv_completed_o <= 1'b0;
                    end
                end
                ST_PREPARE: begin
                    if (loop_finished_i) begin
                        state          <= ST_ADVANCE;
                        data_prepare_o <= 1'b0;
                    end
                end
                ST_ADVANCE: begin
                    if (od_wrap) begin
                        od_base <= '0;
                        id_cnt  <= id_cnt + ID_W'(1);
                    end else begin
                        od_base <= od_base + OD_W'(OD_PAR);
                    end
                    if (last_grp) begin
                        state            <= ST_DONE;
                        busy_o           <= 1'b0;
                        conv_completed_o <= 1'b1;
                    end else begin
                        state          <= ST_PREPARE;
                        data_prepare_o <= 1'b1;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    data_prepare_o   <= 1'b0;
                    busy_o           <= 1'b0;
                    conv_completed_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        od_valid_mask_o = '0;
        for (int k = 0; k < OD_PAR; k++)
            od_valid_mask_o[k] = ({1'b0, od_base} + (OD_W+1)'(k)) < {1'b0, total_od};
    end

    assign weight_od_base_o = od_base;
    assign weight_id_o      = id_cnt;
    assign data_id_o        = id_cnt;

`ifdef CONV_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_cycles_o <= '0;
        else if (start_ok)
            perf_cycles_o <= '0;
        else if (busy_o && (perf_cycles_o != '1))
            perf_cycles_o <= perf_cycles_o + 32'd1;
    end
`endif

endmodule
